// File: rtl/sao_stat_pkg.sv
// rtl/sao_stat_pkg.sv - shared state type, widths and saturating adders for SAO statistics
// Contents: state_t (IDLE/WAIT/SWEEP/DONE), default widths, sat_add_s / sat_add_u.
package sao_stat_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        SWEEP = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int SAO_DIFF_CLIP_BIT = 4;
    localparam int SAO_SUM_W         = 16;
    localparam int SAO_CNT_W         = 12;
    localparam int SAO_S61_W         = SAO_DIFF_CLIP_BIT + 4;

    // Signed add of two sign-extended operands, clamped to a w-bit signed range.
    // The 33-bit intermediate cannot overflow, so the clamp sees the true sum.
    function automatic logic signed [31:0] sat_add_s(input logic signed [31:0] a,
                                                     input logic signed [31:0] b,
                                                     input int w);
        logic signed [32:0] s;
        logic signed [32:0] hi;
        logic signed [32:0] lo;
        s  = $signed({a[31], a}) + $signed({b[31], b});
        hi = (33'sd1 <<< (w - 1)) - 33'sd1;
        lo = -(33'sd1 <<< (w - 1));
        if (s > hi)
            return hi[31:0];
        else if (s < lo)
            return lo[31:0];
        else
            return s[31:0];
    endfunction

    // Unsigned add clamped to 2^w - 1.
    function automatic logic [31:0] sat_add_u(input logic [31:0] a,
                                              input logic [31:0] b,
                                              input int w);
        logic [32:0] s;
        logic [32:0] hi;
        s  = {1'b0, a} + {1'b0, b};
        hi = (33'd1 << w) - 33'd1;
        return (s > hi) ? hi[31:0] : s[31:0];
    endfunction

endpackage

// File: rtl/sao_stat_acc_bank.sv
// rtl/sao_stat_acc_bank.sv - per-category saturating sum and pixel-count registers
// Ports: clk/rst (sync, active-high), clr (zero all entries), upd_en/upd_idx (entry
// updated this cycle), s61 (partial diff sum for upd_idx), cate (latched beat
// categories used for the popcount), sum_out/cnt_out (register contents).
module sao_stat_acc_bank
    import sao_stat_pkg::*;
#(
    parameter int PIX6      = 6,
    parameter int n_bo_type = 5,
    parameter int N_CATE    = 5,
    parameter int SUM_W     = SAO_SUM_W,
    parameter int CNT_W     = SAO_CNT_W,
    parameter int S61_W     = SAO_S61_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic                        upd_en,
    input  logic [n_bo_type-1:0]        upd_idx,
    input  logic signed [S61_W-1:0]     s61,
    input  logic [n_bo_type-1:0]        cate    [0:PIX6-1],
    output logic signed [SUM_W-1:0]     sum_out [0:N_CATE-1],
    output logic [CNT_W-1:0]            cnt_out [0:N_CATE-1]
);

    localparam int POP_W = $clog2(PIX6 + 1);

    logic signed [SUM_W-1:0] r_sum [0:N_CATE-1];
    logic [CNT_W-1:0]        r_cnt [0:N_CATE-1];

    logic [POP_W-1:0]        w_pop;
    logic signed [SUM_W-1:0] w_sum_cur;
    logic signed [SUM_W-1:0] w_sum_nxt;
    logic [CNT_W-1:0]        w_cnt_cur;
    logic [CNT_W-1:0]        w_cnt_nxt;

    // Pixels matching the swept category; codes >= N_CATE are never swept,
    // so they never contribute.
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < PIX6; i++) begin
            if (cate[i] == upd_idx)
                w_pop = w_pop + POP_W'(1);
        end
    end

    always_comb begin
        w_sum_cur = '0;
        w_cnt_cur = '0;
        for (int k = 0; k < N_CATE; k++) begin
            if (upd_idx == n_bo_type'(k)) begin
                w_sum_cur = r_sum[k];
                w_cnt_cur = r_cnt[k];
            end
        end
    end

    assign w_sum_nxt = SUM_W'(sat_add_s(32'(w_sum_cur), 32'(s61), SUM_W));
    assign w_cnt_nxt = CNT_W'(sat_add_u(32'(w_cnt_cur), 32'(w_pop), CNT_W));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int k = 0; k < N_CATE; k++) begin
                r_sum[k] <= '0;
                r_cnt[k] <= '0;
            end
        end else if (upd_en) begin
            for (int k = 0; k < N_CATE; k++) begin
                if (upd_idx == n_bo_type'(k)) begin
                    r_sum[k] <= w_sum_nxt;
                    r_cnt[k] <= w_cnt_nxt;
                end
            end
        end
    end

    assign sum_out = r_sum;
    assign cnt_out = r_cnt;

endmodule

// File: rtl/sao_stat_cate_sched.sv
// rtl/sao_stat_cate_sched.sv - beat latch and category sweep sequencer for SAO statistics
// Ports: clk/rst (sync, active-high); start (begin CTU, IDLE only); in_valid/in_ready/
// in_last with cate/diff (beat input); adder_cate/adder_diff/cate_target (to the shared
// external adder), s61 (its result); sum_out/cnt_out (statistics); busy, done.
module sao_stat_cate_sched
    import sao_stat_pkg::*;
#(
    parameter int PIX6          = 6,
    parameter int diff_clip_bit = SAO_DIFF_CLIP_BIT,
    parameter int n_bo_type     = 5,
    parameter int N_CATE        = 5,
    parameter int SUM_W         = SAO_SUM_W,
    parameter int CNT_W         = SAO_CNT_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_last,
    input  logic [n_bo_type-1:0]          cate        [0:PIX6-1],
    input  logic signed [diff_clip_bit:0] diff        [0:PIX6-1],
    output logic [n_bo_type-1:0]          adder_cate  [0:PIX6-1],
    output logic signed [diff_clip_bit:0] adder_diff  [0:PIX6-1],
    output logic [n_bo_type-1:0]          cate_target,
    input  logic signed [diff_clip_bit+3:0] s61,
    output logic signed [SUM_W-1:0]       sum_out     [0:N_CATE-1],
    output logic [CNT_W-1:0]              cnt_out     [0:N_CATE-1],
    output logic                          busy,
    output logic                          done
);

    localparam int                   S61_W    = diff_clip_bit + 4;
    localparam logic [n_bo_type-1:0] LAST_IDX = n_bo_type'(N_CATE - 1);

    state_t                      r_state;
    logic [n_bo_type-1:0]        r_idx;
    logic                        r_last;
    logic                        r_busy;
    logic                        r_done;
    logic [n_bo_type-1:0]        r_adder_cate [0:PIX6-1];
    logic signed [diff_clip_bit:0] r_adder_diff [0:PIX6-1];

    logic w_sweep_end;
    logic w_in_ready;
    logic w_accept;
    logic w_clr;
    logic w_upd;

    // The next beat may be taken on the final sweep cycle so back-to-back
    // beats cost exactly N_CATE cycles; never after the CTU's last beat.
    assign w_sweep_end = (r_state == SWEEP) && (r_idx == LAST_IDX);
    assign w_in_ready  = (r_state == WAIT) || (w_sweep_end && !r_last);
    assign w_accept    = in_valid && w_in_ready;
    assign w_clr       = (r_state == IDLE) && start;
    assign w_upd       = (r_state == SWEEP);

    // r_idx is returned to 0 whenever SWEEP is left, so it doubles as cate_target.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            for (int i = 0; i < PIX6; i++) begin
                r_adder_cate[i] <= '0;
                r_adder_diff[i] <= '0;
            end
        end else begin
            if (w_accept) begin
                r_last <= in_last;
                for (int i = 0; i < PIX6; i++) begin
                    r_adder_cate[i] <= cate[i];
                    r_adder_diff[i] <= diff[i];
                end
            end
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= WAIT;
                        r_busy  <= 1'b1;
                    end
                end
                WAIT: begin
                    if (w_accept) begin
                        r_state <= SWEEP;
                        r_idx   <= '0;
                    end
                end
                SWEEP: begin
                    if (!w_sweep_end) begin
                        r_idx <= r_idx + n_bo_type'(1);
                    end else begin
                        r_idx <= '0;
                        if (r_last) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else if (!w_accept) begin
                            r_state <= WAIT;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    sao_stat_acc_bank #(
        .PIX6      (PIX6),
        .n_bo_type (n_bo_type),
        .N_CATE    (N_CATE),
        .SUM_W     (SUM_W),
        .CNT_W     (CNT_W),
        .S61_W     (S61_W)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_clr),
        .upd_en  (w_upd),
        .upd_idx (r_idx),
        .s61     (s61),
        .cate    (r_adder_cate),
        .sum_out (sum_out),
        .cnt_out (cnt_out)
    );

    assign in_ready    = w_in_ready;
    assign adder_cate  = r_adder_cate;
    assign adder_diff  = r_adder_diff;
    assign cate_target = r_idx;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule

// File: doc/sao_stat_cate_sched.md
# sao_stat_cate_sched

Sequencer for SAO statistics collection. It latches one 6-pixel beat of (category, clipped diff) pairs and sweeps `cate_target` over all categories, one per cycle, through the shared external `sao_stat_n_add_s61` adder. Each returned `s61` partial sum is accumulated into a per-category saturating sum, and per-category pixel counts are kept alongside. It sits between the SAO classification stage and the offset-decision stage and produces one statistics set per CTU.

## Interface
- `PIX6`, default 6: pixels per beat.
- `diff_clip_bit`, default 4: diff magnitude width; diff is `diff_clip_bit+1` bits signed.
- `n_bo_type`, default 5: category code width.
- `N_CATE`, default 5: number of categories swept, codes 0..N_CATE-1.
- `SUM_W`, default 16: signed accumulator width.
- `CNT_W`, default 12: unsigned count width.

Ports (name, direction, width, meaning):
- `clk` in 1: the single clock.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: begin a CTU; honoured only in IDLE.
- `in_valid` in 1: beat valid.
- `in_ready` out 1: beat accepted when `in_valid & in_ready`.
- `in_last` in 1: accepted beat is the last beat of the CTU.
- `cate[0:PIX6-1]` in `n_bo_type` each: per-pixel category.
- `diff[0:PIX6-1]` in `diff_clip_bit+1` signed each: per-pixel diff.
- `adder_cate` / `adder_diff` out, same shapes: latched beat, driven to the adder.
- `cate_target` out `n_bo_type`: category presented to the adder.
- `s61` in `diff_clip_bit+4` signed: adder result, combinational, same cycle.
- `sum_out[0:N_CATE-1]` out `SUM_W` signed: accumulated diff sums.
- `cnt_out[0:N_CATE-1]` out `CNT_W`: accumulated pixel counts.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse when statistics are final.

## Operation
- States:
  - IDLE: `start` moves to WAIT and clears all `sum_out`/`cnt_out` in the same edge.
  - WAIT: `in_ready`=1. On accept, latch the beat and `in_last` and go to SWEEP with idx=0.
  - SWEEP: `cate_target`=idx. Each cycle:
    - `acc[idx] += sext(s61)`, saturating to [-2^(SUM_W-1), 2^(SUM_W-1)-1].
    - `cnt[idx] +=` popcount(`cate[i]`==idx), saturating at 2^CNT_W-1.
    - idx increments.
  - Leaving SWEEP at idx=N_CATE-1:
    - latched last=1: go to DONE.
    - Otherwise, if a beat is accepted this cycle: SWEEP with idx=0.
    - Otherwise: WAIT.
  - DONE: `done`=1 for one cycle, then IDLE.
- `in_ready`=1 in WAIT, and in SWEEP when idx=N_CATE-1 and the latched last=0. Back-to-back beats therefore cost exactly N_CATE cycles each.
- Pixels whose category is >= N_CATE are never counted or summed.
- `start` outside IDLE is ignored. `in_valid` in IDLE or DONE is not accepted.
- `sum_out`/`cnt_out` hold their values from DONE until the next `start`.
- `cate_target` is 0 whenever the state is not SWEEP.

## Timing
- Reset: state IDLE, idx 0, every output 0, including `sum_out`, `cnt_out`, `adder_*`, `in_ready`, `busy`, `done`.
- Reset mid-sweep aborts the CTU; no `done` is produced.
- `start` at cycle t puts the block in WAIT at t+1.
- A beat accepted at cycle a is swept in cycles a+1..a+N_CATE.
- For a last beat accepted at a, `done` is high at a+N_CATE+1.
- Accumulators update on the edge ending each SWEEP cycle, so the final values are visible while `done` is high.
- When `start` and `rst` are both high, `rst` wins.

## Structure
- Package `sao_stat_pkg`:
  - state enum {IDLE, WAIT, SWEEP, DONE};
  - localparams for `SUM_W`, `CNT_W`, and `s61` width (`diff_clip_bit+4`);
  - saturating-add functions.
- Sub-module `sao_stat_acc_bank`: N_CATE sum/count registers with clear, indexed saturating update, and a per-beat popcount. The FSM and idx counter stay in the top module.
- `sao_stat_n_add_s61` is not instantiated here; it lives in the parent and is shared through `cate_target`/`s61`.

## Test plan
- Single beat:
  - Stimulus: `start`, then one beat with all `cate`=1, all `diff`=+3, `in_last`=1, accepted at cycle 1.
  - Response: `done` at cycle 7; `sum_out[1]`=18, `cnt_out[1]`=6; all others 0; `cate_target` sequence 0,1,2,3,4.
- Mixed beat:
  - Stimulus: `cate`={0,2,2,4,7,2}, `diff`={-16,5,-1,15,9,2}.
  - Response: `sum[0]`=-16, `sum[2]`=6, `sum[4]`=15, `cnt[2]`=3; category 7 ignored.
- Back-to-back:
  - Stimulus: 4 beats with `in_valid` held high.
  - Response: accepts at cycles 1, 6, 11, 16; `done` at 22; sums equal 4 times the single-beat result.
- Saturation:
  - Stimulus: 365 beats with all `cate`=2, `diff`=+15.
  - Response: `sum_out[2]`=32767 (not wrapped); `cnt_out[2]`=2190.
- Reset mid-CTU:
  - Stimulus: `rst` at the second SWEEP cycle.
  - Response: next cycle all outputs 0 and state IDLE; a new CTU then yields correct values.
- Protocol:
  - Stimulus: `start` while busy; `in_valid` held in IDLE.
  - Response: `start` ignored, no accept; `sum_out` from the prior CTU held.
